// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//
// Walks a register index range [FIRST..LAST] through one combinational
// register-file read port. Each (index, value) pair is streamed out on a
// valid/ready interface, one word at a time. The walk wraps modulo NREGS,
// so FIRST > LAST runs through the top index and back to 0.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   START, ABORT             one-cycle command / cancel
//   FIRST, LAST              inclusive index range, sampled on accepted START
//   RA, RD                   register-file read address / combinational data
//   DOUT_VALID, DOUT_READY   output stream handshake
//   DOUT_DATA, DOUT_IDX      captured register value and its index
//   DOUT_LAST                marks the final word of the dump
//   BUSY                     high whenever not idle
//   DONE                     one-cycle pulse after the final word handshakes
module regfile_dump_reader #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [4:0]        FIRST,
    input  logic [4:0]        LAST,
    output logic [4:0]        RA,
    input  logic [DATA_W-1:0] RD,
    output logic              DOUT_VALID,
    input  logic              DOUT_READY,
    output logic [DATA_W-1:0] DOUT_DATA,
    output logic [4:0]        DOUT_IDX,
    output logic              DOUT_LAST,
    output logic              BUSY,
    output logic              DONE
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Walk position and end of range, latched on an accepted START.
    logic [4:0] idx;
    logic [4:0] end_idx;
    // Last address presented in LOAD; RA keeps it outside LOAD.
    logic [4:0] ra_q;

    // Captured output word.
    logic [DATA_W-1:0] data_p1;
    logic [4:0]        idx_p1;
    logic              last_p1;
    logic              vld_p1;
    logic              done_q;

    logic hs;

    assign hs = vld_p1 & DOUT_READY;

    function automatic logic [4:0] idx_inc(input logic [4:0] i);
        return (i == 5'(NREGS - 1)) ? 5'd0 : i + 5'd1;
    endfunction

    // ---- state register ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- next-state logic ----
    // ABORT outranks a coincident handshake; in IDLE only START matters.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (START) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = ABORT ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                if (ABORT)        state_nxt = S_IDLE;
                else if (hs)      state_nxt = last_p1 ? S_IDLE : S_LOAD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- range / walk position (no reset needed: always latched before use) ----
    always_ff @(posedge CLK) begin
        if (state == S_IDLE && START) begin
            idx     <= FIRST;
            end_idx <= LAST;
        end else if (state == S_SEND && !ABORT && hs && !last_p1) begin
            idx     <= idx_inc(idx);
        end
    end

    // ---- capture stage: RD sampled in LOAD, held through SEND ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            ra_q    <= 5'd0;
            data_p1 <= '0;
            idx_p1  <= 5'd0;
            last_p1 <= 1'b0;
            vld_p1  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                S_LOAD: begin
                    ra_q <= idx;
                    if (ABORT) begin
                        vld_p1  <= 1'b0;
                        last_p1 <= 1'b0;
                    end else begin
                        data_p1 <= RD;
                        idx_p1  <= idx;
                        last_p1 <= (idx == end_idx);
                        vld_p1  <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (ABORT) begin
                        vld_p1  <= 1'b0;
                        last_p1 <= 1'b0;
                    end else if (hs) begin
                        vld_p1 <= 1'b0;
                        if (last_p1) done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---- outputs ----
    always_comb begin
        BUSY = (state != S_IDLE);
        RA   = ra_q;
        if (state == S_LOAD) RA = idx;
    end

    assign DOUT_VALID = vld_p1;
    assign DOUT_DATA  = data_p1;
    assign DOUT_IDX   = idx_p1;
    assign DOUT_LAST  = last_p1;
    assign DONE       = done_q;

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Debug/verification read-out engine for the 32 x 32-bit processor register file. On a start command it walks a programmable register index range through one register-file read port and streams each (index, value) pair out over a valid/ready handshake, one word at a time, wrapping past the top index when the range requires. It sits beside the register file on a spare read port (or a muxed A2/RD2 port while the core is halted). Testbenches and the debug host use it to dump architectural state.

## Interface
- NREGS, 32, number of architectural registers; index width fixed at 5 bits; indices wrap modulo NREGS
- CLK  in  1  single clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- START  in  1  one-cycle command; accepted only in IDLE, ignored otherwise
- ABORT  in  1  cancels a dump in progress; no effect in IDLE
- FIRST  in  5  first index to dump; sampled on accepted START
- LAST  in  5  final index to dump; sampled on accepted START
- RA  out  5  register-file read address
- RD  in  32  register-file read data; combinational, valid in the same cycle as RA
- DOUT_VALID  out  1  stream word valid
- DOUT_READY  in  1  downstream ready
- DOUT_DATA  out  32  register value
- DOUT_IDX  out  5  register index of DOUT_DATA
- DOUT_LAST  out  1  marks the final word of the dump
- BUSY  out  1  high in any state other than IDLE
- DONE  out  1  one-cycle pulse after the final word handshakes

## Operation
- States: IDLE, LOAD, SEND.
- IDLE:
  - START=1 latches FIRST into idx and LAST into end_idx, then goes to LOAD.
  - RA holds its last value.
- LOAD:
  - RA=idx.
  - At the edge, DOUT_DATA<=RD, DOUT_IDX<=idx, DOUT_LAST<=(idx==end_idx), DOUT_VALID<=1, then go to SEND.
- SEND:
  - DOUT_VALID=1 and DOUT_DATA/IDX/LAST are held stable until handshake (VALID&READY at an edge).
  - On handshake with DOUT_LAST=1: DOUT_VALID<=0, DONE<=1 for one cycle, go to IDLE.
  - On handshake with DOUT_LAST=0: idx<=(idx+1) mod NREGS, DOUT_VALID<=0, go to LOAD.
- Range:
  - Word count = ((LAST-FIRST) mod NREGS)+1.
  - FIRST==LAST dumps exactly one word.
  - FIRST>LAST wraps through 31 to 0. Example: FIRST=30, LAST=1 yields indices 30, 31, 0, 1.
- Index 0 is read like any other index. It reports whatever the port returns, which is 0 for the register file.
- Snapshot semantics: each word reflects the register contents in its LOAD cycle. Writes landing after that cycle do not alter a word already captured.
- ABORT (any non-IDLE state, at the edge):
  - Goes to IDLE and clears DOUT_VALID and DOUT_LAST.
  - No DONE pulse.
  - ABORT has priority over a coincident handshake.
- START while BUSY is ignored: no relatch, no restart.
- START and ABORT together in IDLE: START wins, because ABORT has no effect in IDLE.

## Timing
- Reset values: RA=0, DOUT_VALID=0, DOUT_DATA=0, DOUT_IDX=0, DOUT_LAST=0, BUSY=0, DONE=0, state=IDLE.
- RST asserted mid-dump returns all outputs to their reset values at the next edge, with no DONE.
- START accepted at edge n: BUSY=1 and LOAD in cycle n+1; DOUT_VALID=1 from cycle n+2.
- With READY held high, throughput is one word per 2 cycles. An N-word dump occupies BUSY for 2N cycles.
- DONE is high in the cycle after the final handshake, the same cycle BUSY returns to 0.
- DOUT_VALID never deasserts without a handshake, except on ABORT or RST.
- No combinational path from DOUT_READY to any output.

## Test plan
- Preload x1..x3 = 0x11, 0x22, 0x33. Drive FIRST=1, LAST=3, READY=1 -> words (1,0x11), (2,0x22), (3,0x33,LAST=1) at cycles n+2, n+4, n+6; DONE at n+7; BUSY low at n+7.
- Wrap: x30=0xA, x31=0xB, x1=0xC. Drive FIRST=30, LAST=1 -> indices 30, 31, 0, 1 with data 0xA, 0xB, 0, 0xC; LAST only on index 1.
- Backpressure: READY low for 5 cycles during word 2 -> DOUT_DATA/IDX/VALID stable all 5 cycles; the word is accepted on the first READY=1 edge; no word lost or duplicated.
- Abort: ABORT during word 2 of a 4-word dump with READY=1 in the same cycle -> IDLE next cycle, VALID=0, no DONE, no word 3. A following START works normally.
- Snapshot/START-while-busy: write x5=0xDEAD after word 5 is captured, and pulse START mid-dump -> the streamed word shows the old x5 value, and FIRST/LAST are not relatched.
- Reset: assert RST mid-dump -> all outputs at reset values next edge, no DONE. FIRST=LAST=7 afterwards -> exactly one word, (7, x7, LAST=1).
